// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and a
// width helper used by the transmitter and the baud counter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } uart_tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // A counter for n states never needs fewer than one bit, even when n is 1.
  function automatic int safeClog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last
// cycle of each bit. Shared between the UART transmitter and receiver.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int CW = safeClog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Clear wins over enable so every new state starts a fresh bit period.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      if (count_q == LAST) begin
        count_d = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_done = (count_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pulls the FIFO head entry, sends one LSB-first frame with
// optional parity, then pops the entry with a single-cycle transmit_complete.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DW           = 7,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          empty,
  input  logic [DW:0]   rd_data,
  output logic          transmit_complete,
  output logic          tx,
  output logic          busy
);

  localparam int IW = safeClog2(DW + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DW);

  uart_tx_state_t state_q;
  uart_tx_state_t state_d;
  logic [DW:0]    shreg_q;
  logic [DW:0]    shreg_d;
  logic [IW-1:0]  bitIdx_q;
  logic [IW-1:0]  bitIdx_d;
  logic           parity_q;
  logic           parity_d;
  logic           tx_q;
  logic           tx_d;
  logic           bitDone;
  logic           cntClear;
  logic           cntEn;

  // The entry is latched once at load, so later rd_data changes cannot leak
  // into the frame; parity is taken from that same latched value.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitIdx_d = bitIdx_q;
    parity_d = parity_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d  = START;
          shreg_d  = rd_data;
          bitIdx_d = '0;
          parity_d = (^rd_data) ^ (PARITY == PAR_ODD);
        end
      end
      START: begin
        if (bitDone) state_d = DATA;
      end
      DATA: begin
        if (bitDone) begin
          if (bitIdx_q == LAST_BIT) begin
            state_d = (PARITY != PAR_NONE) ? PAR : STOP;
          end else begin
            bitIdx_d = bitIdx_q + IW'(1);
            shreg_d  = shreg_q >> 1;
          end
        end
      end
      PAR: begin
        if (bitDone) state_d = STOP;
      end
      STOP: begin
        if (bitDone) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line level is decoded from the upcoming state and registered, so tx
  // switches on the same edge as the state and never glitches.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PAR:     tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign cntClear = (state_d != state_q);
  assign cntEn    = (state_q == START) || (state_q == DATA) ||
                    (state_q == PAR)   || (state_q == STOP);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uBaud (
    .clk     (clk),
    .reset   (reset),
    .clear   (cntClear),
    .en      (cntEn),
    .bit_done(bitDone)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitIdx_q <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitIdx_q <= bitIdx_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign tx                = tx_q;
  assign busy              = (state_q != IDLE);
  assign transmit_complete = (state_q == DONE);

endmodule
